// File: rtl/spi_dac_master.sv
// SPI master for a serial DAC: one MSB-first frame per start pulse, SCLK idle high,
// with SYNC framing, data changing on SCLK rise, and a guaranteed SYNC-high gap.
module spi_dac_master #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 2,
  parameter int CS_HIGH    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_fRST,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_spi_data,
  output logic [2:0]            o_spi_state,
  output logic                  o_spi_sclk,
  output logic                  o_spi_cs_n,
  output logic                  o_spi_mosi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One timer serves both the SCLK half-period and the SYNC-high hold.
  localparam int CNT_MAX = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH - 1);
  localparam logic [4:0]       LAST_BIT  = 5'(DATA_WIDTH - 1);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        div_reg, div_next;
  logic [4:0]              bit_reg, bit_next;
  logic [DATA_WIDTH-1:0]   shreg_reg, shreg_next;
  logic                    sclk_reg, sclk_next;
  logic                    cs_n_reg, cs_n_next;

  always_ff @(posedge i_clk or negedge i_fRST) begin
    if (!i_fRST) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      bit_reg   <= '0;
      shreg_reg <= '0;
      sclk_reg  <= 1'b1;
      cs_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
      shreg_reg <= shreg_next;
      sclk_reg  <= sclk_next;
      cs_n_reg  <= cs_n_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    shreg_next = shreg_reg;
    sclk_next  = sclk_reg;
    cs_n_next  = cs_n_reg;
    case (state_reg)
      IDLE: begin
        sclk_next = 1'b1;
        cs_n_next = 1'b1;
        div_next  = '0;
        bit_next  = '0;
        if (i_spi_start) begin
          state_next = SETUP;
          shreg_next = i_spi_data;
          cs_n_next  = 1'b0;
        end
      end
      SETUP: begin
        if (div_reg == DIV_LAST) begin
          state_next = SHIFT;
          div_next   = '0;
          sclk_next  = 1'b0;
        end else begin
          div_next = div_reg + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          // MOSI is the shift-register MSB, so shifting on the rise presents the next bit.
          if (!sclk_reg) begin
            sclk_next  = 1'b1;
            shreg_next = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
          end else if (bit_reg == LAST_BIT) begin
            state_next = HOLD;
            cs_n_next  = 1'b1;
            shreg_next = '0;
          end else begin
            bit_next  = bit_reg + 5'd1;
            sclk_next = 1'b0;
          end
        end else begin
          div_next = div_reg + CNT_W'(1);
        end
      end
      HOLD: begin
        if (div_reg == HOLD_LAST) begin
          state_next = DONE;
          div_next   = '0;
        end else begin
          div_next = div_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        div_next   = '0;
        bit_next   = '0;
        shreg_next = '0;
        sclk_next  = 1'b1;
        cs_n_next  = 1'b1;
      end
    endcase
  end

  assign o_spi_state = state_reg;
  assign o_spi_sclk  = sclk_reg;
  assign o_spi_cs_n  = cs_n_reg;
  assign o_spi_mosi  = shreg_reg[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_dac_master.sv
// Bench for spi_dac_master: default-parameter instance A and a fast instance B
// (CLK_DIV=1, CS_HIGH=1), checked against frame-level timing and data expectations.
module tb_spi_dac_master;

  localparam int DW    = 24;
  localparam int CD_A  = 2;
  localparam int CSH_A = 4;
  localparam int CD_B  = 1;
  localparam int CSH_B = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic [2:0]    state_a, state_b;
  logic          sclk_a, sclk_b, cs_a, cs_b, mosi_a, mosi_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            falls;
    logic [DW-1:0] captured;
    int            cs_low;
    int            done_edge;
    int            done_cycles;
    int            mosi_bad;
    int            tail_high;
    bit            timeout;
  } frame_obs_t;

  always #5 clk = ~clk;

  spi_dac_master #(.DATA_WIDTH(DW), .CLK_DIV(CD_A), .CS_HIGH(CSH_A)) dut_a (
    .i_clk(clk), .i_fRST(rst_n), .i_spi_start(start_a), .i_spi_data(data_a),
    .o_spi_state(state_a), .o_spi_sclk(sclk_a), .o_spi_cs_n(cs_a), .o_spi_mosi(mosi_a)
  );

  spi_dac_master #(.DATA_WIDTH(DW), .CLK_DIV(CD_B), .CS_HIGH(CSH_B)) dut_b (
    .i_clk(clk), .i_fRST(rst_n), .i_spi_start(start_b), .i_spi_data(data_b),
    .o_spi_state(state_b), .o_spi_sclk(sclk_b), .o_spi_cs_n(cs_b), .o_spi_mosi(mosi_b)
  );

  // Frame-level model: SYNC low spans setup plus 2*DW half periods; DONE follows the hold.
  function automatic int model_cs_low(input int cd);
    return cd * (2 * DW + 1);
  endfunction

  function automatic int model_done_edge(input int cd, input int csh);
    return cd * (2 * DW + 1) + csh;
  endfunction

  task automatic drive_start(input int which, input logic v);
    if (which == 0) start_a = v; else start_b = v;
  endtask

  task automatic drive_data(input int which, input logic [DW-1:0] d);
    if (which == 0) data_a = d; else data_b = d;
  endtask

  task automatic sample(input int which, output logic [2:0] s, output logic sc,
                        output logic cs, output logic mo);
    if (which == 0) begin s = state_a; sc = sclk_a; cs = cs_a; mo = mosi_a; end
    else            begin s = state_b; sc = sclk_b; cs = cs_b; mo = mosi_b; end
  endtask

  // Called right after a negedge; pulses start and records what the DAC would see.
  task automatic watch_frame(input int which, input logic [DW-1:0] d, input bit clear_data,
                             input int extra_at, output frame_obs_t o);
    logic [2:0] s;
    logic sc, cs, mo, prev;
    bit seen_low;
    o.falls = 0; o.captured = '0; o.cs_low = 0; o.done_edge = -1; o.done_cycles = 0;
    o.mosi_bad = 0; o.tail_high = 0; o.timeout = 1'b1;
    seen_low = 1'b0;
    sample(which, s, prev, cs, mo);
    drive_data(which, d);
    drive_start(which, 1'b1);
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (j == 0) begin
        drive_start(which, 1'b0);
        if (clear_data) drive_data(which, '0);
      end
      if (j == extra_at) drive_start(which, 1'b1);
      else if (j == extra_at + 1) drive_start(which, 1'b0);
      sample(which, s, sc, cs, mo);
      if (prev && !sc) begin
        o.falls++;
        o.captured = {o.captured[DW-2:0], mo};
      end
      if (!cs) begin
        o.cs_low++;
        seen_low = 1'b1;
      end else begin
        if (seen_low) o.tail_high++;
        if (mo !== 1'b0) o.mosi_bad++;
      end
      if (s == 3'd4) begin
        o.done_cycles++;
        if (o.done_edge < 0) o.done_edge = j;
      end
      prev = sc;
      if (o.done_edge >= 0 && s == 3'd0) begin
        o.timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic watch_idle(input int which, input int n, output int falls,
                            output int cs_low, output int non_idle);
    logic [2:0] s;
    logic sc, cs, mo, prev;
    falls = 0; cs_low = 0; non_idle = 0;
    sample(which, s, prev, cs, mo);
    repeat (n) begin
      @(negedge clk);
      sample(which, s, sc, cs, mo);
      if (prev && !sc) falls++;
      if (!cs) cs_low++;
      if (s != 3'd0) non_idle++;
      prev = sc;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL reset_state_a got %0d exp 0", state_a); end
    checks++; if ({sclk_a, cs_a, mosi_a} !== 3'b110) begin errors++; $display("FAIL reset_pins_a got %b exp 110", {sclk_a, cs_a, mosi_a}); end
    checks++; if (state_b !== 3'd0) begin errors++; $display("FAIL reset_state_b got %0d exp 0", state_b); end
    checks++; if ({sclk_b, cs_b, mosi_b} !== 3'b110) begin errors++; $display("FAIL reset_pins_b got %b exp 110", {sclk_b, cs_b, mosi_b}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    frame_obs_t o;
    watch_frame(0, 24'h18ABCD, 1'b0, -1, o);
    checks++; if (o.timeout) begin errors++; $display("FAIL single_timeout got timeout exp DONE"); end
    checks++; if (o.falls !== DW) begin errors++; $display("FAIL single_falls got %0d exp %0d", o.falls, DW); end
    checks++; if (o.captured !== 24'h18ABCD) begin errors++; $display("FAIL single_data got %h exp 18abcd", o.captured); end
    checks++; if (o.cs_low !== 98) begin errors++; $display("FAIL single_cs_low got %0d exp 98", o.cs_low); end
    checks++; if (o.done_edge !== 102) begin errors++; $display("FAIL single_done_edge got %0d exp 102", o.done_edge); end
    checks++; if (o.done_cycles !== 1) begin errors++; $display("FAIL single_done_cycles got %0d exp 1", o.done_cycles); end
    checks++; if (o.mosi_bad !== 0) begin errors++; $display("FAIL single_mosi_idle got %0d exp 0", o.mosi_bad); end
    $display("single frame data=%h captured=%h done_edge=%0d", 24'h18ABCD, o.captured, o.done_edge);
  endtask

  task automatic test_data_change();
    frame_obs_t o;
    logic [DW-1:0] d;
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? 24'h000001 : DW'($urandom);
      watch_frame(0, d, 1'b1, -1, o);
      checks++; if (o.captured !== d) begin errors++; $display("FAIL data_change_%0d got %h exp %h", k, o.captured, d); end
      checks++; if (o.falls !== DW) begin errors++; $display("FAIL data_change_falls_%0d got %0d exp %0d", k, o.falls, DW); end
      $display("data change frame %0d sent=%h captured=%h", k, d, o.captured);
    end
  endtask

  task automatic test_random_frames();
    frame_obs_t o;
    logic [DW-1:0] d;
    int which, cd, csh;
    for (int k = 0; k < 10; k++) begin
      which = (k % 3 == 2) ? 1 : 0;
      cd  = (which == 0) ? CD_A : CD_B;
      csh = (which == 0) ? CSH_A : CSH_B;
      d = DW'($urandom);
      watch_frame(which, d, 1'b0, -1, o);
      checks++; if (o.timeout) begin errors++; $display("FAIL rand_timeout_%0d got timeout exp DONE", k); end
      checks++; if (o.captured !== d) begin errors++; $display("FAIL rand_data_%0d got %h exp %h", k, o.captured, d); end
      checks++; if (o.falls !== DW) begin errors++; $display("FAIL rand_falls_%0d got %0d exp %0d", k, o.falls, DW); end
      checks++; if (o.cs_low !== model_cs_low(cd)) begin errors++; $display("FAIL rand_cs_low_%0d got %0d exp %0d", k, o.cs_low, model_cs_low(cd)); end
      checks++; if (o.done_edge !== model_done_edge(cd, csh)) begin errors++; $display("FAIL rand_done_%0d got %0d exp %0d", k, o.done_edge, model_done_edge(cd, csh)); end
      checks++; if (o.done_cycles !== 1 || o.mosi_bad !== 0) begin errors++; $display("FAIL rand_misc_%0d got done=%0d mosi_bad=%0d exp 1/0", k, o.done_cycles, o.mosi_bad); end
      $display("random frame %0d dut=%0d sent=%h captured=%h done_edge=%0d", k, which, d, o.captured, o.done_edge);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    frame_obs_t o;
    int falls, cs_low, non_idle;
    logic [DW-1:0] d;
    d = DW'($urandom);
    watch_frame(0, d, 1'b0, 44, o);
    watch_idle(0, 30, falls, cs_low, non_idle);
    checks++; if (o.falls !== DW) begin errors++; $display("FAIL busy_falls got %0d exp %0d", o.falls, DW); end
    checks++; if (o.captured !== d) begin errors++; $display("FAIL busy_data got %h exp %h", o.captured, d); end
    checks++; if (o.done_edge !== 102 || o.done_cycles !== 1) begin errors++; $display("FAIL busy_done got edge=%0d cycles=%0d exp 102/1", o.done_edge, o.done_cycles); end
    checks++; if (falls !== 0 || cs_low !== 0 || non_idle !== 0) begin errors++; $display("FAIL busy_extra got falls=%0d cs_low=%0d busy=%0d exp 0", falls, cs_low, non_idle); end
    $display("start while busy sent=%h captured=%h trailing_falls=%0d", d, o.captured, falls);
  endtask

  task automatic test_back_to_back();
    frame_obs_t o1, o2;
    logic [DW-1:0] d1, d2;
    d1 = DW'($urandom);
    d2 = DW'($urandom);
    watch_frame(0, d1, 1'b0, -1, o1);
    watch_frame(0, d2, 1'b0, -1, o2);
    checks++; if (o1.captured !== d1) begin errors++; $display("FAIL b2b_first got %h exp %h", o1.captured, d1); end
    checks++; if (o2.captured !== d2 || o2.falls !== DW) begin errors++; $display("FAIL b2b_second got %h/%0d exp %h/%0d", o2.captured, o2.falls, d2, DW); end
    checks++; if (o1.tail_high < CSH_A + 2) begin errors++; $display("FAIL b2b_gap got %0d exp >= %0d", o1.tail_high, CSH_A + 2); end
    checks++; if (o2.done_edge !== 102) begin errors++; $display("FAIL b2b_done got %0d exp 102", o2.done_edge); end
    $display("back to back %h then %h gap=%0d", o1.captured, o2.captured, o1.tail_high);
  endtask

  task automatic test_reset_mid_frame();
    int falls, cs_low, non_idle;
    start_a = 1'b1;
    data_a = DW'($urandom);
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (j == 0) start_a = 1'b0;
    end
    checks++; if (state_a !== 3'd2 || sclk_a !== 1'b0) begin errors++; $display("FAIL midrst_pre got state=%0d sclk=%b exp 2/0", state_a, sclk_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state_a !== 3'd0) begin errors++; $display("FAIL midrst_state got %0d exp 0", state_a); end
    checks++; if ({sclk_a, cs_a, mosi_a} !== 3'b110) begin errors++; $display("FAIL midrst_pins got %b exp 110", {sclk_a, cs_a, mosi_a}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    watch_idle(0, 150, falls, cs_low, non_idle);
    checks++; if (falls !== 0 || cs_low !== 0 || non_idle !== 0) begin errors++; $display("FAIL midrst_after got falls=%0d cs_low=%0d busy=%0d exp 0", falls, cs_low, non_idle); end
    $display("reset mid frame trailing falls=%0d busy_cycles=%0d", falls, non_idle);
  endtask

  task automatic test_param_sweep();
    frame_obs_t o;
    watch_frame(1, 24'hFFFFFF, 1'b0, -1, o);
    checks++; if (o.falls !== DW) begin errors++; $display("FAIL sweep_falls got %0d exp %0d", o.falls, DW); end
    checks++; if (o.done_edge !== 50) begin errors++; $display("FAIL sweep_done got %0d exp 50", o.done_edge); end
    checks++; if (o.captured !== 24'hFFFFFF) begin errors++; $display("FAIL sweep_data got %h exp ffffff", o.captured); end
    checks++; if (o.cs_low !== 49) begin errors++; $display("FAIL sweep_cs_low got %0d exp 49", o.cs_low); end
    $display("param sweep captured=%h done_edge=%0d", o.captured, o.done_edge);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_data_change();
    test_random_frames();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
